// File: rtl/pio_in_edge_irq.sv
// pio_in_edge_irq: Avalon-MM input PIO with synchroniser, debounce, edge capture and level irq
// Ports:
//   clk, reset_n            system clock, asynchronous active-low reset
//   address, chipselect,    Avalon-MM slave; register map: 0 data (RO), 1 reserved,
//   write_n, writedata,     2 irq_mask (RW), 3 edge_capture (write 1 to clear)
//   readdata                registered read data, fixed 1-cycle latency
//   in_port                 asynchronous board inputs
//   irq                     registered level interrupt, |(edge_capture & irq_mask)
module pio_in_edge_irq #(
    parameter int WIDTH           = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] f_d;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] rd_next;
    logic             wr;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
            assign f = s;
        end else begin : g_deb
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            logic [CW-1:0]    cnt [WIDTH];
            logic [WIDTH-1:0] f_q;
            // cnt counts consecutive cycles where s disagrees with f; any agreement restarts it
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    f_q <= '0;
                    for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (s[i] == f_q[i]) begin
                            cnt[i] <= '0;
                        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                            f_q[i] <= s[i];
                            cnt[i] <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CW'(1);
                        end
                    end
                end
            end
            assign f = f_q;
        end
    endgenerate

    always_comb begin
        wr      = chipselect & ~write_n;
        ev      = EDGE_TYPE == 0 ? (f & ~f_d) :
                  EDGE_TYPE == 1 ? (~f & f_d) :
                                   (f ^ f_d);
        clr     = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        rd_next = address == 2'd0 ? f :
                  address == 2'd2 ? irq_mask :
                  address == 2'd3 ? edge_capture : '0;
    end

    // Read path and irq sample the pre-update registers, so a read of
    // edge_capture sees the bits before this cycle's set or clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_d          <= '0;
            edge_capture <= '0;
            irq_mask     <= '0;
            readdata     <= '0;
            irq          <= 1'b0;
        end else begin
            f_d          <= f;
            edge_capture <= ev | (edge_capture & ~clr);
            irq_mask     <= (wr && address == 2'd2) ? writedata[WIDTH-1:0] : irq_mask;
            readdata     <= 32'(rd_next);
            irq          <= |(edge_capture & irq_mask);
        end
    end
endmodule

// File: tb/tb_pio_in_edge_irq.sv
// tb_pio_in_edge_irq: four parameter variants checked against a history-based model every cycle
module tb_pio_in_edge_irq;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [4:0]  in_port = '0;
    logic [31:0] rd [4];
    logic        irq [4];
    int          n_tot = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    pio_in_edge_irq #(.WIDTH(5), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd[0]), .in_port(in_port), .irq(irq[0]));
    pio_in_edge_irq #(.WIDTH(5), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd[1]), .in_port(in_port), .irq(irq[1]));
    pio_in_edge_irq #(.WIDTH(5), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) u_c (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd[2]), .in_port(in_port), .irq(irq[2]));
    pio_in_edge_irq #(.WIDTH(5), .SYNC_STAGES(4), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(1)) u_d (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd[3]), .in_port(in_port), .irq(irq[3]));

    function automatic int sy(int k);
        return k == 2 ? 3 : k == 3 ? 4 : 2;
    endfunction
    function automatic int db(int k);
        return k == 1 ? 4 : k == 3 ? 1 : 0;
    endfunction
    function automatic int et(int k);
        return k == 2 ? 2 : k == 3 ? 1 : 0;
    endfunction

    // Model: in_port and s kept as sample histories; f flips once the last
    // DEBOUNCE samples of s all disagree with it.
    logic [4:0] ih [4][8];
    logic [4:0] sh [4][8];
    int         nv [4];
    logic [4:0] mf [4], mfd [4], mcap [4], mmask [4], mrd [4];
    logic       mirq [4];

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 8; j++) begin
                ih[k][j] = '0;
                sh[k][j] = '0;
            end
            nv[k] = 0; mf[k] = '0; mfd[k] = '0; mcap[k] = '0; mmask[k] = '0; mrd[k] = '0; mirq[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [4:0] s_o, f_o, rise, fall, ev, clr;
        logic       wr, flip;
        wr = chipselect && !write_n;
        for (int k = 0; k < 4; k++) begin
            s_o  = ih[k][sy(k)-1];
            f_o  = db(k) == 0 ? s_o : mf[k];
            rise = f_o & ~mfd[k];
            fall = ~f_o & mfd[k];
            ev   = et(k) == 0 ? rise : et(k) == 1 ? fall : (rise | fall);
            clr  = (wr && address == 2'd3) ? writedata[4:0] : 5'd0;
            mrd[k]  = address == 2'd0 ? f_o : address == 2'd2 ? mmask[k] : address == 2'd3 ? mcap[k] : 5'd0;
            mirq[k] = |(mcap[k] & mmask[k]);
            mcap[k] = ev | (mcap[k] & ~clr);
            if (wr && address == 2'd2) mmask[k] = writedata[4:0];
            mfd[k] = f_o;
            for (int j = 7; j > 0; j--) begin
                ih[k][j] = ih[k][j-1];
                sh[k][j] = sh[k][j-1];
            end
            ih[k][0] = in_port;
            sh[k][0] = s_o;
            if (nv[k] < 8) nv[k]++;
            if (db(k) > 0) begin
                for (int i = 0; i < 5; i++) begin
                    flip = nv[k] >= db(k);
                    for (int j = 0; j < db(k); j++) if (sh[k][j][i] == mf[k][i]) flip = 1'b0;
                    if (flip) mf[k][i] = ~mf[k][i];
                end
            end
        end
    endtask

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_tot++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        else n_pass++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rd%0d", k), rd[k], {27'd0, mrd[k]});
            chk($sformatf("irq%0d", k), {31'd0, irq[k]}, {31'd0, mirq[k]});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic settle(logic [4:0] v);
        in_port = v;
        repeat (12) step();
        wr(2'd3, 32'h1F);
    endtask

    initial begin
        int hold;
        repeat (3) step();
        reset_n = 1'b1;
        // reset state
        address = 2'd0; step(); chk("rst_data", rd[0], 0); chk("rst_irq", {31'd0, irq[0]}, 0);
        address = 2'd2; step(); chk("rst_mask", rd[0], 0);
        address = 2'd3; step(); chk("rst_cap", rd[0], 0);
        // basic rising capture and W1C
        wr(2'd2, 32'h1);
        address = 2'd0; in_port = 5'h15;
        repeat (2) step(); chk("data_early", rd[0], 0);
        step(); chk("data_15", rd[0], 32'h15); chk("mdl_cap_a", {27'd0, mcap[0]}, 32'h15);
        chk("irq_not_yet", {31'd0, irq[0]}, 0);
        address = 2'd3; step(); chk("irq_set", {31'd0, irq[0]}, 1); chk("cap_15", rd[0], 32'h15);
        wr(2'd3, 32'h1); chk("cap_pre_clr", rd[0], 32'h15); chk("irq_hold", {31'd0, irq[0]}, 1);
        step(); chk("cap_14", rd[0], 32'h14); chk("irq_drop", {31'd0, irq[0]}, 0);
        // debounce rejects a short pulse, accepts a long one
        settle(5'h00);
        address = 2'd0; in_port = 5'h01;
        repeat (3) step();
        in_port = 5'h00;
        for (int i = 0; i < 10; i++) begin step(); chk("deb_glitch", rd[1], 0); end
        address = 2'd3; step(); chk("deb_glitch_cap", rd[1], 0);
        address = 2'd0; in_port = 5'h01;
        repeat (6) step(); chk("deb_before", rd[1], 0);
        step(); chk("deb_after", rd[1], 1); chk("mdl_f_b", {27'd0, mf[1]}, 1);
        address = 2'd3; step(); chk("deb_cap", rd[1], 1);
        // any-edge capture, clear coinciding with the second edge
        settle(5'h00);
        address = 2'd3; in_port = 5'h04;
        repeat (6) step(); chk("any_first", rd[2], 32'h04);
        in_port = 5'h00;
        repeat (3) step();
        wr(2'd3, 32'h04);
        step(); chk("any_clr_race", rd[2], 32'h04); chk("mdl_cap_c", {27'd0, mcap[2]}, 32'h04);
        // mask gating
        wr(2'd2, 32'h0);
        settle(5'h00);
        in_port = 5'h1F;
        repeat (4) step();
        address = 2'd3; step(); chk("mask_cap", rd[0], 32'h1F); chk("mask_irq0", {31'd0, irq[0]}, 0);
        wr(2'd2, 32'h10); chk("mask_irq_lat", {31'd0, irq[0]}, 0);
        step(); chk("mask_irq1", {31'd0, irq[0]}, 1);
        wr(2'd3, 32'h0); address = 2'd3;
        step(); chk("w0_nochange", rd[0], 32'h1F);
        // async reset mid-debounce with irq high
        in_port = 5'h00;
        repeat (4) step();
        chk("pre_rst_irq", {31'd0, irq[0]}, 1);
        #1 reset_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("async_rd", rd[k], 0);
            chk("async_irq", {31'd0, irq[k]}, 0);
        end
        in_port = 5'h1F;
        repeat (2) step();
        reset_n = 1'b1;
        address = 2'd3;
        repeat (3) step(); chk("post_rst_cap0", rd[0], 0);
        step(); chk("post_rst_cap", rd[0], 32'h1F);
        // randomized traffic
        hold = 1;
        for (int c = 0; c < 3000; c++) begin
            if (--hold == 0) begin
                in_port = in_port ^ 5'($urandom);
                hold = $urandom_range(1, 8);
            end
            chipselect = ($urandom % 3) == 0;
            write_n = $urandom % 2;
            address = 2'($urandom);
            writedata = $urandom;
            if (c == 1500) begin
                #1 reset_n = 1'b0;
                step();
                reset_n = 1'b1;
            end else begin
                step();
            end
        end
        chipselect = 1'b0; write_n = 1'b1;
        step();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
